oaram_writer: RTL

OARAM_WRITER -- requirements
Module: oaram_writer

---
 rtl/oaram_writer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/oaram_writer.sv
// oaram_writer: packs compressed lane entries into OARAM words, emits one record per channel.
// Optional write-overflow guard enabled by defining OARAM_WRITER_OVF_DETECT_EN.
module oaram_writer #(
  parameter int NLANE    = 4,
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 4,
  parameter int WORD_ENT = 8,
  parameter int ADDR_W   = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NLANE-1:0]                 in_valid,
  input  logic [NLANE*DATA_W-1:0]          in_data,
  input  logic [NLANE*IDX_W-1:0]           in_idx,
  input  logic                             chan_end,
  input  logic                             finish_en,
  output logic                             wr_en,
  output logic [ADDR_W-1:0]                wr_addr,
  output logic [WORD_ENT*(DATA_W+IDX_W)-1:0] wr_data,
  output logic [WORD_ENT-1:0]              wr_mask,
  output logic                             rec_valid,
  output logic [ADDR_W-1:0]                rec_base,
  output logic [15:0]                      rec_count,
  output logic                             done,
  output logic                             err,
  output logic                             ovf
);
  localparam int ENT_W  = DATA_W + IDX_W;
  localparam int BUF_N  = WORD_ENT + NLANE - 1;
  localparam int FILL_W = $clog2(BUF_N + 1);
  localparam logic [FILL_W-1:0] WE_F = FILL_W'(WORD_ENT);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t              state;
  logic [ENT_W-1:0]    stg_q [BUF_N];
  logic [ENT_W-1:0]    stg_d [BUF_N];
  logic [ENT_W-1:0]    cat   [BUF_N];
  logic [FILL_W-1:0]   fill_q, fill_d, total, nb;
  logic [ADDR_W-1:0]   addr_q, rec_base_q;
  logic [15:0]         cnt_q, rec_count_q, cnt_sum;
  logic [16:0]         sum17;
  logic                fin_q, rec_valid_q, done_q, err_q;
  logic                beat, endp, accept, new_ch, noncontig, full_word, wr_req, wr_blk;

  assign beat   = |in_valid;
  assign endp   = chan_end | finish_en;
  assign accept = !rst && (state != FLUSH);
  assign new_ch = (state == IDLE || state == DONE) && (beat || endp);

  // Append valid lanes after the current fill, compacting out gaps.
  always_comb begin
    int  pos;
    logic gap;
    pos       = int'(fill_q);
    gap       = 1'b0;
    noncontig = 1'b0;
    for (int s = 0; s < BUF_N; s++) cat[s] = stg_q[s];
    for (int l = 0; l < NLANE; l++) begin
      if (!in_valid[l]) begin
        gap = 1'b1;
      end else begin
        if (gap) noncontig = 1'b1;
        for (int s = 0; s < BUF_N; s++)
          if (s == pos) cat[s] = {in_idx[l*IDX_W +: IDX_W], in_data[l*DATA_W +: DATA_W]};
        pos++;
      end
    end
    total = FILL_W'(pos);
  end

  assign nb        = total - fill_q;
  assign sum17     = {1'b0, (new_ch ? 16'd0 : cnt_q)} + 17'(nb);
  assign cnt_sum   = sum17[16] ? 16'hFFFF : sum17[15:0];
  assign full_word = accept && (total >= WE_F);

  always_comb begin
    for (int s = 0; s < BUF_N; s++) stg_d[s] = '0;
    if (full_word) begin
      for (int s = 0; s < BUF_N - WORD_ENT; s++) stg_d[s] = cat[s + WORD_ENT];
      fill_d = total - WE_F;
    end else begin
      for (int s = 0; s < BUF_N; s++) stg_d[s] = cat[s];
      fill_d = total;
    end
  end

  assign wr_req = !rst && (state == FLUSH || full_word);
  assign wr_en  = wr_req && !wr_blk;

  always_comb begin
    wr_data = '0;
    wr_mask = '0;
    if (wr_en) begin
      for (int e = 0; e < WORD_ENT; e++) begin
        if (state == FLUSH) begin
          wr_data[e*ENT_W +: ENT_W] = stg_q[e];
          wr_mask[e]                = (FILL_W'(e) < fill_q);
        end else begin
          wr_data[e*ENT_W +: ENT_W] = cat[e];
          wr_mask[e]                = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      for (int s = 0; s < BUF_N; s++) stg_q[s] <= '0;
      fill_q      <= '0;
      addr_q      <= '0;
      rec_base_q  <= '0;
      rec_count_q <= '0;
      cnt_q       <= '0;
      fin_q       <= 1'b0;
      rec_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rec_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (wr_en) addr_q <= addr_q + 1'b1;
      if (state == FLUSH) begin
        // Inputs cannot be absorbed while the residue word goes out.
        if (beat || endp) err_q <= 1'b1;
        for (int s = 0; s < BUF_N; s++) stg_q[s] <= '0;
        fill_q <= '0;
        state  <= fin_q ? DONE : IDLE;
        done_q <= fin_q;
        fin_q  <= 1'b0;
      end else begin
        if (noncontig) err_q <= 1'b1;
        stg_q  <= stg_d;
        fill_q <= fill_d;
        if (new_ch) rec_base_q <= addr_q;
        if (endp) begin
          rec_valid_q <= 1'b1;
          rec_count_q <= cnt_sum;
          cnt_q       <= '0;
          if (fill_d != '0) begin
            state <= FLUSH;
            fin_q <= finish_en;
          end else begin
            state  <= finish_en ? DONE : IDLE;
            done_q <= finish_en;
          end
        end else if (beat) begin
          state <= RUN;
          cnt_q <= cnt_sum;
        end
      end
    end
  end

`ifdef OARAM_WRITER_OVF_DETECT_EN
  logic full_q, ovf_q;
  // Once the top address has been written, the OARAM is full until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en && addr_q == '1) full_q <= 1'b1;
      if (wr_req && full_q)      ovf_q  <= 1'b1;
    end
  end
  assign wr_blk = full_q;
  assign ovf    = ovf_q;
`else
  assign wr_blk = 1'b0;
  assign ovf    = 1'b0;
`endif

  assign wr_addr   = addr_q;
  assign rec_valid = rec_valid_q;
  assign rec_base  = rec_base_q;
  assign rec_count = rec_count_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule
